// File: rtl/udp_loopback_pktq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | udp_loopback_pktq                                                        |
// | Store-and-forward payload/descriptor queue between UDP rx and tx engines |
// | with atomic discard and inter-packet gap pacing.                         |
// | Option macro: UDP_LOOPBACK_ERR_DROP_EN (rx_pkt_err forces a drop).       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module udp_loopback_pktq #(
  parameter int DATA_AW = 11,
  parameter int PKT_AW  = 2,
  parameter int GAP_CYC = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              rx_pkt_done,
  input  logic              rx_pkt_err,
  input  logic [47:0]       rx_mac,
  input  logic [31:0]       rx_ip,
  input  logic [15:0]       rx_port,
  input  logic [15:0]       rx_len,
  output logic              tx_start,
  output logic [47:0]       tx_mac,
  output logic [31:0]       tx_ip,
  output logic [15:0]       tx_port,
  output logic [15:0]       tx_len,
  input  logic              tx_req,
  output logic [7:0]        tx_data,
  input  logic              tx_done,
  output logic [PKT_AW:0]   pkt_cnt,
  output logic [15:0]       drop_cnt
);

  localparam int PTR_W = DATA_AW + 1;
  localparam int DEPTH = 1 << DATA_AW;
  localparam int PKT_N = 1 << PKT_AW;
  localparam logic [PTR_W-1:0]  C_FULL_USED = PTR_W'(DEPTH);
  localparam logic [PKT_AW:0]   C_FIFO_FULL = (PKT_AW+1)'(PKT_N);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_SEND  = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  logic [7:0]       mem      [DEPTH];
  logic [47:0]      dq_mac   [PKT_N];
  logic [31:0]      dq_ip    [PKT_N];
  logic [15:0]      dq_port  [PKT_N];
  logic [15:0]      dq_len   [PKT_N];
  logic [PTR_W-1:0] dq_start [PKT_N];

  logic [PTR_W-1:0] wr_spec_q, wr_spec_d, wr_cmt_q, wr_cmt_d, rd_q, rd_d;
  logic [15:0]      byte_cnt_q, byte_cnt_d, drop_cnt_q, drop_cnt_d;
  logic             bad_q, bad_d;
  logic [PKT_AW:0]  dwp_q, dwp_d, drp_q, drp_d;
  state_t           state_q, state_d;
  logic             tx_start_q, tx_start_d;
  logic [47:0]      tx_mac_q, tx_mac_d;
  logic [31:0]      tx_ip_q, tx_ip_d;
  logic [15:0]      tx_port_q, tx_port_d, tx_len_q, tx_len_d;
  logic [PTR_W-1:0] tx_base_q, tx_base_d;
  logic [15:0]      served_q, served_d, gap_q, gap_d;
  logic [7:0]       tx_data_q, tx_data_d;

  logic [PTR_W-1:0] w_used, w_spec_nxt;
  logic [15:0]      w_cnt_nxt;
  logic [PKT_AW:0]  w_pkt_cnt;
  logic             w_full, w_wr_en, w_bad_nxt, w_fifo_full, w_err_ok, w_commit, w_pop;
  logic [PKT_AW-1:0] w_head;
  logic [7:0]       w_rd_byte;

`ifdef UDP_LOOPBACK_ERR_DROP_EN
  assign w_err_ok = ~rx_pkt_err;
`else
  logic w_unused_err;
  assign w_unused_err = rx_pkt_err;
  assign w_err_ok     = 1'b1;
`endif

  assign w_used      = wr_spec_q - rd_q;
  assign w_full      = (w_used == C_FULL_USED);
  assign w_wr_en     = rx_valid & ~w_full;
  // A byte arriving with rx_pkt_done belongs to the finishing packet.
  assign w_spec_nxt  = wr_spec_q + PTR_W'(w_wr_en);
  assign w_cnt_nxt   = byte_cnt_q + 16'(rx_valid);
  assign w_bad_nxt   = bad_q | (rx_valid & w_full);
  assign w_pkt_cnt   = dwp_q - drp_q;
  assign w_fifo_full = (w_pkt_cnt == C_FIFO_FULL);
  assign w_commit    = rx_pkt_done & ~w_bad_nxt & (w_cnt_nxt == rx_len) &
                       (rx_len != 16'd0) & ~w_fifo_full & w_err_ok;
  assign w_head      = drp_q[PKT_AW-1:0];
  assign w_rd_byte   = mem[rd_q[DATA_AW-1:0]];

  always_ff @(posedge clk) begin
    if (w_wr_en) mem[wr_spec_q[DATA_AW-1:0]] <= rx_data;
    if (w_commit) begin
      dq_mac[dwp_q[PKT_AW-1:0]]   <= rx_mac;
      dq_ip[dwp_q[PKT_AW-1:0]]    <= rx_ip;
      dq_port[dwp_q[PKT_AW-1:0]]  <= rx_port;
      dq_len[dwp_q[PKT_AW-1:0]]   <= rx_len;
      dq_start[dwp_q[PKT_AW-1:0]] <= wr_cmt_q;
    end
  end

  always_comb begin
    wr_spec_d  = w_spec_nxt;
    wr_cmt_d   = wr_cmt_q;
    byte_cnt_d = w_cnt_nxt;
    bad_d      = w_bad_nxt;
    drop_cnt_d = drop_cnt_q;
    dwp_d      = dwp_q + (PKT_AW+1)'(w_commit);
    if (rx_pkt_done) begin
      byte_cnt_d = 16'd0;
      bad_d      = 1'b0;
      if (w_commit) begin
        wr_cmt_d = w_spec_nxt;
      end else begin
        wr_spec_d = wr_cmt_q;
        if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    tx_start_d = 1'b0;
    tx_mac_d   = tx_mac_q;
    tx_ip_d    = tx_ip_q;
    tx_port_d  = tx_port_q;
    tx_len_d   = tx_len_q;
    tx_base_d  = tx_base_q;
    rd_d       = rd_q;
    served_d   = served_q;
    gap_d      = gap_q;
    tx_data_d  = tx_data_q;
    w_pop      = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Descriptor is latched on entry so it is already valid with tx_start.
        if (w_pkt_cnt != '0) begin
          state_d    = S_START;
          tx_start_d = 1'b1;
          tx_mac_d   = dq_mac[w_head];
          tx_ip_d    = dq_ip[w_head];
          tx_port_d  = dq_port[w_head];
          tx_len_d   = dq_len[w_head];
          tx_base_d  = dq_start[w_head];
        end
      end
      S_START: begin
        rd_d     = tx_base_q;
        served_d = 16'd0;
        state_d  = S_SEND;
      end
      S_SEND: begin
        if (tx_req) begin
          if (served_q < tx_len_q) begin
            tx_data_d = w_rd_byte;
            rd_d      = rd_q + PTR_W'(1);
            served_d  = served_q + 16'd1;
          end else begin
            tx_data_d = 8'h00;
          end
        end
        if (tx_done) begin
          rd_d    = tx_base_q + tx_len_q[PTR_W-1:0];
          w_pop   = 1'b1;
          gap_d   = 16'd0;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (({1'b0, gap_q} + 17'd1) >= 17'(GAP_CYC)) state_d = S_IDLE;
        else                                         gap_d   = gap_q + 16'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign drp_d = drp_q + (PKT_AW+1)'(w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_spec_q  <= '0;
      wr_cmt_q   <= '0;
      rd_q       <= '0;
      byte_cnt_q <= '0;
      bad_q      <= 1'b0;
      drop_cnt_q <= '0;
      dwp_q      <= '0;
      drp_q      <= '0;
      state_q    <= S_IDLE;
      tx_start_q <= 1'b0;
      tx_mac_q   <= '0;
      tx_ip_q    <= '0;
      tx_port_q  <= '0;
      tx_len_q   <= '0;
      tx_base_q  <= '0;
      served_q   <= '0;
      gap_q      <= '0;
      tx_data_q  <= '0;
    end else begin
      wr_spec_q  <= wr_spec_d;
      wr_cmt_q   <= wr_cmt_d;
      rd_q       <= rd_d;
      byte_cnt_q <= byte_cnt_d;
      bad_q      <= bad_d;
      drop_cnt_q <= drop_cnt_d;
      dwp_q      <= dwp_d;
      drp_q      <= drp_d;
      state_q    <= state_d;
      tx_start_q <= tx_start_d;
      tx_mac_q   <= tx_mac_d;
      tx_ip_q    <= tx_ip_d;
      tx_port_q  <= tx_port_d;
      tx_len_q   <= tx_len_d;
      tx_base_q  <= tx_base_d;
      served_q   <= served_d;
      gap_q      <= gap_d;
      tx_data_q  <= tx_data_d;
    end
  end

  assign tx_start = tx_start_q;
  assign tx_mac   = tx_mac_q;
  assign tx_ip    = tx_ip_q;
  assign tx_port  = tx_port_q;
  assign tx_len   = tx_len_q;
  assign tx_data  = tx_data_q;
  assign pkt_cnt  = w_pkt_cnt;
  assign drop_cnt = drop_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_udp_loopback_pktq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_udp_loopback_pktq                                                     |
// | Directed bench: 2 KiB instance for the main traffic, 64 B instance for   |
// | the overflow/wrap case; sel chooses whose outputs are observed.          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_udp_loopback_pktq;
  localparam int GAP = 12;
`ifdef UDP_LOOPBACK_ERR_DROP_EN
  localparam bit ERR_DROP = 1'b1;
`else
  localparam bit ERR_DROP = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0, sel = 1'b0;
  logic rx_valid = 1'b0, rx_pkt_done = 1'b0, rx_pkt_err = 1'b0;
  logic [7:0] rx_data = '0;
  logic [47:0] rx_mac = '0;
  logic [31:0] rx_ip = '0;
  logic [15:0] rx_port = '0, rx_len = '0;
  logic tx_req = 1'b0, tx_done = 1'b0;

  logic b_start, s_start;
  logic [47:0] b_mac, s_mac;
  logic [31:0] b_ip, s_ip;
  logic [15:0] b_port, s_port, b_len, s_len, b_drop, s_drop;
  logic [7:0] b_data, s_data;
  logic [2:0] b_cnt, s_cnt;

  logic m_tx_start;
  logic [111:0] m_desc;
  logic [7:0] m_tx_data;
  logic [2:0] m_pkt_cnt;
  logic [15:0] m_drop_cnt;

  assign m_tx_start = sel ? s_start : b_start;
  assign m_desc     = sel ? {s_mac, s_ip, s_port, s_len} : {b_mac, b_ip, b_port, b_len};
  assign m_tx_data  = sel ? s_data : b_data;
  assign m_pkt_cnt  = sel ? s_cnt : b_cnt;
  assign m_drop_cnt = sel ? s_drop : b_drop;

  udp_loopback_pktq #(.DATA_AW(11), .PKT_AW(2), .GAP_CYC(GAP)) u_big (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_pkt_done(rx_pkt_done), .rx_pkt_err(rx_pkt_err), .rx_mac(rx_mac),
    .rx_ip(rx_ip), .rx_port(rx_port), .rx_len(rx_len), .tx_start(b_start),
    .tx_mac(b_mac), .tx_ip(b_ip), .tx_port(b_port), .tx_len(b_len),
    .tx_req(tx_req), .tx_data(b_data), .tx_done(tx_done), .pkt_cnt(b_cnt),
    .drop_cnt(b_drop));

  udp_loopback_pktq #(.DATA_AW(6), .PKT_AW(2), .GAP_CYC(GAP)) u_small (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_pkt_done(rx_pkt_done), .rx_pkt_err(rx_pkt_err), .rx_mac(rx_mac),
    .rx_ip(rx_ip), .rx_port(rx_port), .rx_len(rx_len), .tx_start(s_start),
    .tx_mac(s_mac), .tx_ip(s_ip), .tx_port(s_port), .tx_len(s_len),
    .tx_req(tx_req), .tx_data(s_data), .tx_done(tx_done), .pkt_cnt(s_cnt),
    .drop_cnt(s_drop));

  always #4 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [15:0] nbytes;
    logic [15:0] len;
    logic [31:0] ip;
    logic [15:0] port;
    logic        err;
    logic        tail;
    logic [15:0] nreq;
    logic [7:0]  base;
    logic        echo;
  } vec_t;

  vec_t tbl [9];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic set_hdr(input logic [15:0] len, input logic [31:0] ip,
                         input logic [15:0] port, input logic err);
    rx_pkt_done = 1'b1;
    rx_pkt_err  = err;
    rx_mac      = {16'h0200, ip};
    rx_ip       = ip;
    rx_port     = port;
    rx_len      = len;
  endtask

  task automatic send_pkt(input int n, input logic [15:0] len, input logic [31:0] ip,
                          input logic [15:0] port, input logic err, input logic [7:0] base,
                          input logic tail);
    for (int i = 0; i < n; i++) begin
      rx_valid = 1'b1;
      rx_data  = base + 8'(i);
      if (tail && i == n - 1) set_hdr(len, ip, port, err);
      tick();
    end
    rx_valid = 1'b0;
    if (!tail || n == 0) begin
      set_hdr(len, ip, port, err);
      tick();
    end
    rx_pkt_done = 1'b0;
    rx_pkt_err  = 1'b0;
  endtask

  task automatic wait_start(output int cyc);
    cyc = 0;
    while (!m_tx_start && cyc < 400) begin
      tick();
      cyc++;
    end
    if (!m_tx_start) cyc = -1;
  endtask

  // Plays the transmit engine: checks the descriptor, pulls nreq bytes, ends with tx_done.
  task automatic serve(input string name, input logic [7:0] base, input logic [15:0] len,
                       input int nreq, input logic [31:0] ip, input logic [15:0] port);
    int nbad;
    logic [7:0] exp;
    check({name, "_desc"}, 128'(m_desc), 128'({{16'h0200, ip}, ip, port, len}));
    if (m_tx_start) tick();
    nbad = 0;
    for (int i = 0; i < nreq; i++) begin
      tx_req = 1'b1;
      tick();
      exp = (i < int'(len)) ? base + 8'(i) : 8'h00;
      if (m_tx_data !== exp) nbad++;
    end
    tx_req = 1'b0;
    check({name, "_bad_bytes"}, 128'(nbad), 128'(0));
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cyc;
    int exp_drops;
    logic seen;

    // nbytes, len, ip, port, err, tail, nreq, base, echo
    tbl[0] = '{16'd16, 16'd16, 32'hC0A8_0001, 16'h1388, 1'b0, 1'b0, 16'd16, 8'h00, 1'b1};
    tbl[1] = '{16'd18, 16'd20, 32'hC0A8_0002, 16'h1389, 1'b0, 1'b0, 16'd18, 8'h20, 1'b0};
    tbl[2] = '{16'd20, 16'd20, 32'hC0A8_0003, 16'h138A, 1'b0, 1'b1, 16'd20, 8'h40, 1'b1};
    tbl[3] = '{16'd0,  16'd0,  32'hC0A8_0004, 16'h138B, 1'b0, 1'b0, 16'd0,  8'h00, 1'b0};
    tbl[4] = '{16'd8,  16'd8,  32'hC0A8_0005, 16'h138C, 1'b1, 1'b0, 16'd8,  8'h60, ~ERR_DROP};
    tbl[5] = '{16'd10, 16'd10, 32'hC0A8_0006, 16'h138D, 1'b0, 1'b0, 16'd12, 8'h70, 1'b1};
    tbl[6] = '{16'd12, 16'd12, 32'hC0A8_0007, 16'h138E, 1'b0, 1'b1, 16'd5,  8'h90, 1'b1};
    tbl[7] = '{16'd6,  16'd6,  32'hC0A8_0008, 16'h138F, 1'b0, 1'b0, 16'd6,  8'hA0, 1'b1};
    tbl[8] = '{16'd9,  16'd8,  32'hC0A8_0009, 16'h1390, 1'b0, 1'b0, 16'd9,  8'hB0, 1'b0};

    tick();
    check("reset_big", 128'({b_start, b_mac, b_ip, b_port, b_len, b_data, b_cnt, b_drop}), 128'(0));
    check("reset_small", 128'({s_start, s_mac, s_ip, s_port, s_len, s_data, s_cnt, s_drop}), 128'(0));
    rst_n = 1'b1;
    tick();

    // Table-driven single packets on the 2 KiB instance.
    sel = 1'b0;
    exp_drops = 0;
    for (int k = 0; k < 9; k++) begin
      send_pkt(int'(tbl[k].nbytes), tbl[k].len, tbl[k].ip, tbl[k].port, tbl[k].err,
               tbl[k].base, tbl[k].tail);
      if (tbl[k].echo) begin
        check($sformatf("v%0d_pkt_cnt", k), 128'(m_pkt_cnt), 128'(1));
        wait_start(cyc);
        check($sformatf("v%0d_start_latency", k), 128'(cyc), 128'(1));
        serve($sformatf("v%0d", k), tbl[k].base, tbl[k].len, int'(tbl[k].nreq),
              tbl[k].ip, tbl[k].port);
        check($sformatf("v%0d_pkt_cnt_after", k), 128'(m_pkt_cnt), 128'(0));
        repeat (GAP + 3) tick();
      end else begin
        exp_drops++;
        seen = 1'b0;
        for (int c = 0; c < GAP + 4; c++) begin
          tick();
          if (m_tx_start) seen = 1'b1;
        end
        check($sformatf("v%0d_no_start", k), 128'(seen), 128'(0));
        check($sformatf("v%0d_pkt_cnt", k), 128'(m_pkt_cnt), 128'(0));
      end
      check($sformatf("v%0d_drop_cnt", k), 128'(m_drop_cnt), 128'(exp_drops));
    end

    // Four queued 100-byte packets, fifth overflows the descriptor FIFO.
    do_reset();
    for (int k = 0; k < 4; k++)
      send_pkt(100, 16'd100, 32'h0A00_0010 + 32'(k), 16'h2000 + 16'(k), 1'b0, 8'(k * 50 + 3), 1'b0);
    check("b2b_pkt_cnt4", 128'(m_pkt_cnt), 128'(4));
    send_pkt(100, 16'd100, 32'h0A00_0020, 16'h2004, 1'b0, 8'hEE, 1'b0);
    check("b2b_drop_cnt", 128'(m_drop_cnt), 128'(1));
    check("b2b_pkt_cnt_still4", 128'(m_pkt_cnt), 128'(4));
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin
        wait_start(cyc);
        check($sformatf("b2b_spacing%0d", k), 128'(cyc + 1), 128'(GAP + 2));
      end
      serve($sformatf("b2b%0d", k), 8'(k * 50 + 3), 16'd100, 100,
            32'h0A00_0010 + 32'(k), 16'h2000 + 16'(k));
    end
    check("b2b_pkt_cnt_end", 128'(m_pkt_cnt), 128'(0));
    repeat (GAP + 3) tick();

    // 64-byte instance: oversize drop, then a packet wrapping the byte buffer.
    sel = 1'b1;
    do_reset();
    send_pkt(40, 16'd40, 32'h0B00_0001, 16'h3000, 1'b0, 8'h10, 1'b0);
    wait_start(cyc);
    check("wrap_pre_latency", 128'(cyc), 128'(1));
    serve("wrap_pre", 8'h10, 16'd40, 40, 32'h0B00_0001, 16'h3000);
    repeat (GAP + 3) tick();
    send_pkt(70, 16'd70, 32'h0B00_0002, 16'h3001, 1'b0, 8'h50, 1'b0);
    check("wrap_oversize_drop", 128'(m_drop_cnt), 128'(1));
    check("wrap_oversize_pkt_cnt", 128'(m_pkt_cnt), 128'(0));
    send_pkt(60, 16'd60, 32'h0B00_0003, 16'h3002, 1'b0, 8'h80, 1'b0);
    wait_start(cyc);
    check("wrap_latency", 128'(cyc), 128'(1));
    serve("wrap", 8'h80, 16'd60, 60, 32'h0B00_0003, 16'h3002);
    check("wrap_drop_cnt", 128'(m_drop_cnt), 128'(1));
    repeat (GAP + 3) tick();

    // Reset in the middle of SEND with a second packet still queued.
    sel = 1'b0;
    do_reset();
    send_pkt(5, 16'd6, 32'h0C00_0000, 16'h4000, 1'b0, 8'h01, 1'b0);
    send_pkt(16, 16'd16, 32'h0C00_0001, 16'h4001, 1'b0, 8'h55, 1'b0);
    wait_start(cyc);
    tick();
    tx_req = 1'b1;
    repeat (3) tick();
    tx_req = 1'b0;
    send_pkt(8, 16'd8, 32'h0C00_0002, 16'h4002, 1'b0, 8'h77, 1'b0);
    check("rst_pre_pkt_cnt", 128'(m_pkt_cnt), 128'(2));
    rst_n = 1'b0;
    #1;
    check("rst_outputs", 128'({m_tx_start, m_desc, m_tx_data, m_pkt_cnt, m_drop_cnt}), 128'(0));
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    send_pkt(12, 16'd12, 32'h0C00_0003, 16'h4003, 1'b0, 8'h33, 1'b0);
    wait_start(cyc);
    check("post_rst_latency", 128'(cyc), 128'(1));
    serve("post_rst", 8'h33, 16'd12, 12, 32'h0C00_0003, 16'h4003);
    check("post_rst_pkt_cnt", 128'(m_pkt_cnt), 128'(0));
    check("post_rst_drop_cnt", 128'(m_drop_cnt), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
